// File: rtl/dep_scoreboard.sv
// Decode-stage dependency scoreboard: per-register and CC in-flight write counters,
// incremented on issue and decremented on writeback; dep_stall is combinational.
module dep_scoreboard #(
  parameter int NUM_REGS  = 8,
  parameter int REG_W     = 3,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                chk_valid,
  input  logic [REG_W-1:0]    sr1,
  input  logic                sr1_needed,
  input  logic [REG_W-1:0]    sr2,
  input  logic                sr2_needed,
  input  logic                chk_is_br,
  input  logic [REG_W-1:0]    chk_dr,
  input  logic                chk_ld_reg,
  input  logic                chk_ld_cc,
  input  logic                issue_en,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_dr,
  input  logic                wb_ld_reg,
  input  logic                wb_ld_cc,
  input  logic                flush,
  output logic                dep_stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                cc_busy,
  output logic                err
);

  localparam int             IDS     = 2 ** REG_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic           BYP     = (WB_BYPASS != 0);

  logic [CNT_W-1:0]    cnt     [NUM_REGS];
  logic [CNT_W-1:0]    cnt_nxt [NUM_REGS];
  logic [CNT_W-1:0]    cc_cnt, cc_nxt;
  logic [NUM_REGS-1:0] inc, dec, hz_vec, full_vec, busy_nxt;
  logic [IDS-1:0]      hz_pad, full_pad;
  logic                ret_reg, ret_cc, issue, cc_inc, cc_hz, ovf, underflow;

  // Hazard and stall evaluation; padding to 2**REG_W makes out-of-range IDs read as "no hazard".
  always_comb begin
    ret_reg  = wb_valid & wb_ld_reg;
    ret_cc   = wb_valid & wb_ld_cc;
    dec      = '0;
    hz_vec   = '0;
    full_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      dec[i]      = ret_reg & (wb_dr == REG_W'(i));
      hz_vec[i]   = (cnt[i] != '0) & ~(BYP & (cnt[i] == CNT_ONE) & dec[i]);
      full_vec[i] = (cnt[i] == CNT_MAX) & ~dec[i];
    end
    hz_pad                  = '0;
    hz_pad[NUM_REGS-1:0]    = hz_vec;
    full_pad                = '0;
    full_pad[NUM_REGS-1:0]  = full_vec;
    cc_hz = (cc_cnt != '0) & ~(BYP & (cc_cnt == CNT_ONE) & ret_cc);
    ovf   = (chk_ld_reg & full_pad[chk_dr]) |
            (chk_ld_cc & (cc_cnt == CNT_MAX) & ~ret_cc);
    dep_stall = chk_valid & ((sr1_needed & hz_pad[sr1]) |
                             (sr2_needed & hz_pad[sr2]) |
                             (chk_is_br & cc_hz) | ovf);
    issue  = chk_valid & issue_en & ~dep_stall;
    cc_inc = issue & chk_ld_cc;
    inc    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc[i] = issue & chk_ld_reg & (chk_dr == REG_W'(i));
    end
  end

  // Counter next-state; a retire against an empty counter holds it at zero and flags underflow.
  always_comb begin
    underflow = 1'b0;
    busy_nxt  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (inc[i] & ~dec[i]) begin
        cnt_nxt[i] = cnt[i] + CNT_ONE;
      end else if (dec[i] & ~inc[i]) begin
        if (cnt[i] == '0) underflow = 1'b1;
        else              cnt_nxt[i] = cnt[i] - CNT_ONE;
      end
      busy_nxt[i] = (cnt_nxt[i] != '0);
    end
    cc_nxt = cc_cnt;
    if (cc_inc & ~ret_cc) begin
      cc_nxt = cc_cnt + CNT_ONE;
    end else if (ret_cc & ~cc_inc) begin
      if (cc_cnt == '0) underflow = 1'b1;
      else              cc_nxt = cc_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      cc_cnt   <= '0;
      busy_vec <= '0;
      cc_busy  <= 1'b0;
      err      <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      cc_cnt   <= '0;
      busy_vec <= '0;
      cc_busy  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= cnt_nxt[i];
      cc_cnt   <= cc_nxt;
      busy_vec <= busy_nxt;
      cc_busy  <= (cc_nxt != '0);
      err      <= err | underflow;
    end
  end

endmodule

// File: tb/tb_dep_scoreboard.sv
// Bench for dep_scoreboard: two instances (WB_BYPASS=0 and 1) share stimulus and are
// compared against an integer-count reference model.
module tb_dep_scoreboard;

  logic       clk = 1'b0;
  logic       reset, chk_valid, sr1_needed, sr2_needed, chk_is_br;
  logic       chk_ld_reg, chk_ld_cc, issue_en, wb_valid, wb_ld_reg, wb_ld_cc, flush;
  logic [2:0] sr1, sr2, chk_dr, wb_dr;

  logic [1:0]      stall_o, cc_busy_o, err_o;
  logic [1:0][7:0] busy_o;

  int cmp_cnt = 0;
  int bad_cnt = 0;

  // Reference state: index 0 = no bypass, index 1 = bypass.
  int m_cnt [2][8];
  int m_cc  [2];
  bit m_err [2];

  always #5 clk = ~clk;

  dep_scoreboard #(.WB_BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .chk_valid(chk_valid),
    .sr1(sr1), .sr1_needed(sr1_needed), .sr2(sr2), .sr2_needed(sr2_needed),
    .chk_is_br(chk_is_br), .chk_dr(chk_dr), .chk_ld_reg(chk_ld_reg), .chk_ld_cc(chk_ld_cc),
    .issue_en(issue_en), .wb_valid(wb_valid), .wb_dr(wb_dr), .wb_ld_reg(wb_ld_reg),
    .wb_ld_cc(wb_ld_cc), .flush(flush), .dep_stall(stall_o[0]), .busy_vec(busy_o[0]),
    .cc_busy(cc_busy_o[0]), .err(err_o[0])
  );

  dep_scoreboard #(.WB_BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .chk_valid(chk_valid),
    .sr1(sr1), .sr1_needed(sr1_needed), .sr2(sr2), .sr2_needed(sr2_needed),
    .chk_is_br(chk_is_br), .chk_dr(chk_dr), .chk_ld_reg(chk_ld_reg), .chk_ld_cc(chk_ld_cc),
    .issue_en(issue_en), .wb_valid(wb_valid), .wb_dr(wb_dr), .wb_ld_reg(wb_ld_reg),
    .wb_ld_cc(wb_ld_cc), .flush(flush), .dep_stall(stall_o[1]), .busy_vec(busy_o[1]),
    .cc_busy(cc_busy_o[1]), .err(err_o[1])
  );

  function automatic bit model_hz(int k, int c, bit ret, bit match);
    return (c > 0) && !((k == 1) && (c == 1) && ret && match);
  endfunction

  function automatic bit model_stall(int k);
    bit rr, rc, ovf;
    rr  = wb_valid && wb_ld_reg;
    rc  = wb_valid && wb_ld_cc;
    ovf = (chk_ld_reg && m_cnt[k][chk_dr] == 3 && !(rr && wb_dr == chk_dr)) ||
          (chk_ld_cc && m_cc[k] == 3 && !rc);
    return chk_valid && ((sr1_needed && model_hz(k, m_cnt[k][sr1], rr, wb_dr == sr1)) ||
                         (sr2_needed && model_hz(k, m_cnt[k][sr2], rr, wb_dr == sr2)) ||
                         (chk_is_br && model_hz(k, m_cc[k], rc, 1'b1)) || ovf);
  endfunction

  function automatic logic [7:0] model_busy(int k);
    logic [7:0] b;
    for (int r = 0; r < 8; r++) b[r] = (m_cnt[k][r] > 0);
    return b;
  endfunction

  task automatic clear_inputs();
    chk_valid = 0; sr1 = 0; sr1_needed = 0; sr2 = 0; sr2_needed = 0; chk_is_br = 0;
    chk_dr = 0; chk_ld_reg = 0; chk_ld_cc = 0; issue_en = 0;
    wb_valid = 0; wb_dr = 0; wb_ld_reg = 0; wb_ld_cc = 0; flush = 0;
  endtask

  // Advance one clock and move the reference model by the spec's counting rules.
  task automatic tick();
    bit st [2];
    bit iss, rr, rc;
    int n;
    for (int k = 0; k < 2; k++) st[k] = model_stall(k);
    @(posedge clk);
    rr = wb_valid && wb_ld_reg;
    rc = wb_valid && wb_ld_cc;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int r = 0; r < 8; r++) m_cnt[k][r] = 0;
        m_cc[k] = 0; m_err[k] = 0;
      end else if (flush) begin
        for (int r = 0; r < 8; r++) m_cnt[k][r] = 0;
        m_cc[k] = 0;
      end else begin
        iss = chk_valid && issue_en && !st[k];
        for (int r = 0; r < 8; r++) begin
          n = m_cnt[k][r] + int'(iss && chk_ld_reg && chk_dr == r) - int'(rr && wb_dr == r);
          if (n < 0) begin n = 0; m_err[k] = 1; end
          m_cnt[k][r] = n;
        end
        n = m_cc[k] + int'(iss && chk_ld_cc) - int'(rc);
        if (n < 0) begin n = 0; m_err[k] = 1; end
        m_cc[k] = n;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; tick(); reset = 0;
    chk_valid = 1; sr1 = 3; sr1_needed = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      cmp_cnt += 3;
      if (stall_o[k] !== 1'b0) begin bad_cnt++; $display("FAIL reset_stall[%0d]: got %b want 0", k, stall_o[k]); end
      if (busy_o[k] !== 8'h00) begin bad_cnt++; $display("FAIL reset_busy[%0d]: got %h want 00", k, busy_o[k]); end
      if (err_o[k] !== 1'b0 || cc_busy_o[k] !== 1'b0) begin
        bad_cnt++; $display("FAIL reset_err_cc[%0d]: got %b%b want 00", k, err_o[k], cc_busy_o[k]);
      end
    end
    tick();
  endtask

  task automatic test_raw_hazard();
    logic [1:0] want;
    clear_inputs();
    chk_valid = 1; chk_dr = 3; chk_ld_reg = 1; issue_en = 1;
    tick();
    clear_inputs();
    chk_valid = 1; sr2 = 3; sr2_needed = 1; issue_en = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      cmp_cnt += 2;
      if (busy_o[k] !== 8'h08) begin bad_cnt++; $display("FAIL raw_busy[%0d]: got %h want 08", k, busy_o[k]); end
      if (stall_o[k] !== 1'b1) begin bad_cnt++; $display("FAIL raw_stall[%0d]: got %b want 1", k, stall_o[k]); end
    end
    tick();
    wb_valid = 1; wb_dr = 3; wb_ld_reg = 1;
    @(negedge clk);
    want = 2'b01;  // bypass instance unstalls in the retire cycle
    cmp_cnt++;
    if (stall_o !== want) begin bad_cnt++; $display("FAIL raw_retire_stall: got %b want %b", stall_o, want); end
    tick();
    wb_valid = 0; wb_ld_reg = 0;
    @(negedge clk);
    cmp_cnt++;
    if (stall_o !== 2'b00 || busy_o[0] !== 8'h00 || busy_o[1] !== 8'h00) begin
      bad_cnt++; $display("FAIL raw_after: got stall %b busy %h/%h want 00 00/00", stall_o, busy_o[0], busy_o[1]);
    end
    tick();
  endtask

  task automatic test_overflow();
    clear_inputs();
    chk_valid = 1; chk_dr = 5; chk_ld_reg = 1; issue_en = 1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      cmp_cnt++;
      if (stall_o !== 2'b00) begin bad_cnt++; $display("FAIL ovf_fill%0d: got %b want 00", n, stall_o); end
      tick();
    end
    @(negedge clk);
    cmp_cnt++;
    if (stall_o !== 2'b11) begin bad_cnt++; $display("FAIL ovf_full: got %b want 11", stall_o); end
    tick();
    wb_valid = 1; wb_dr = 5; wb_ld_reg = 1;
    @(negedge clk);
    cmp_cnt++;
    if (stall_o !== 2'b00) begin bad_cnt++; $display("FAIL ovf_retire_issue: got %b want 00", stall_o); end
    tick();
    chk_valid = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      cmp_cnt++;
      if (busy_o[0] !== 8'h20 || busy_o[1] !== 8'h20) begin
        bad_cnt++; $display("FAIL ovf_drain%0d: got %h/%h want 20", n, busy_o[0], busy_o[1]);
      end
      tick();
    end
    clear_inputs();
    @(negedge clk);
    cmp_cnt++;
    if (busy_o[0] !== 8'h00 || busy_o[1] !== 8'h00 || err_o !== 2'b00) begin
      bad_cnt++; $display("FAIL ovf_empty: got %h/%h err %b want 00/00 err 00", busy_o[0], busy_o[1], err_o);
    end
  endtask

  task automatic test_cc();
    clear_inputs();
    chk_valid = 1; chk_ld_cc = 1; issue_en = 1;
    tick();
    clear_inputs();
    chk_valid = 1; chk_is_br = 1; issue_en = 1;
    @(negedge clk);
    cmp_cnt += 2;
    if (stall_o !== 2'b11) begin bad_cnt++; $display("FAIL cc_br_stall: got %b want 11", stall_o); end
    if (cc_busy_o !== 2'b11) begin bad_cnt++; $display("FAIL cc_busy: got %b want 11", cc_busy_o); end
    chk_is_br = 0; issue_en = 0;
    #1;
    cmp_cnt++;
    if (stall_o !== 2'b00) begin bad_cnt++; $display("FAIL cc_nonbr: got %b want 00", stall_o); end
    tick();
    chk_is_br = 1; issue_en = 1; wb_valid = 1; wb_ld_cc = 1;
    @(negedge clk);
    cmp_cnt++;
    if (stall_o !== 2'b01) begin bad_cnt++; $display("FAIL cc_retire: got %b want 01", stall_o); end
    tick();
    wb_valid = 0; wb_ld_cc = 0;
    @(negedge clk);
    cmp_cnt++;
    if (stall_o !== 2'b00 || cc_busy_o !== 2'b00) begin
      bad_cnt++; $display("FAIL cc_after: got stall %b ccb %b want 00 00", stall_o, cc_busy_o);
    end
    tick();
  endtask

  task automatic test_flush();
    clear_inputs();
    chk_valid = 1; chk_dr = 1; chk_ld_reg = 1; chk_ld_cc = 1; issue_en = 1;
    tick(); tick();
    chk_dr = 2; chk_ld_cc = 0;
    wb_valid = 1; wb_dr = 1; wb_ld_reg = 1; flush = 1;
    tick();
    clear_inputs();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      cmp_cnt++;
      if (busy_o[k] !== 8'h00 || cc_busy_o[k] !== 1'b0 || err_o[k] !== 1'b0) begin
        bad_cnt++;
        $display("FAIL flush[%0d]: got busy %h cc %b err %b want 00 0 0", k, busy_o[k], cc_busy_o[k], err_o[k]);
      end
    end
  endtask

  task automatic test_underflow();
    clear_inputs();
    wb_valid = 1; wb_dr = 2; wb_ld_reg = 1;
    tick();
    clear_inputs();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      cmp_cnt++;
      if (err_o !== 2'b11 || busy_o[0] !== 8'h00 || busy_o[1] !== 8'h00) begin
        bad_cnt++; $display("FAIL underflow%0d: got err %b busy %h/%h want 11 00/00", n, err_o, busy_o[0], busy_o[1]);
      end
      tick();
    end
    reset = 1; tick(); reset = 0;
    @(negedge clk);
    cmp_cnt++;
    if (err_o !== 2'b00) begin bad_cnt++; $display("FAIL underflow_reset: got %b want 00", err_o); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      chk_valid  = ($urandom_range(3) != 0);
      sr1        = 3'($urandom_range(7));
      sr1_needed = $urandom_range(1);
      sr2        = 3'($urandom_range(7));
      sr2_needed = $urandom_range(1);
      chk_is_br  = ($urandom_range(4) == 0);
      chk_dr     = 3'($urandom_range(7));
      chk_ld_reg = ($urandom_range(3) != 0);
      chk_ld_cc  = $urandom_range(1);
      issue_en   = ($urandom_range(9) < 7);
      wb_valid   = ($urandom_range(9) < 4);
      wb_dr      = 3'($urandom_range(7));
      wb_ld_reg  = ($urandom_range(3) != 0);
      wb_ld_cc   = $urandom_range(1);
      flush      = ($urandom_range(49) == 0);
      reset      = ($urandom_range(99) == 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        cmp_cnt += 4;
        if (stall_o[k] !== model_stall(k)) begin
          bad_cnt++; $display("FAIL rnd_stall[%0d] cyc %0d: got %b want %b", k, c, stall_o[k], model_stall(k));
        end
        if (busy_o[k] !== model_busy(k)) begin
          bad_cnt++; $display("FAIL rnd_busy[%0d] cyc %0d: got %h want %h", k, c, busy_o[k], model_busy(k));
        end
        if (cc_busy_o[k] !== (m_cc[k] > 0)) begin
          bad_cnt++; $display("FAIL rnd_cc_busy[%0d] cyc %0d: got %b want %b", k, c, cc_busy_o[k], m_cc[k] > 0);
        end
        if (err_o[k] !== m_err[k]) begin
          bad_cnt++; $display("FAIL rnd_err[%0d] cyc %0d: got %b want %b", k, c, err_o[k], m_err[k]);
        end
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    #1;
    test_reset();
    test_raw_hazard();
    test_overflow();
    test_cc();
    test_flush();
    test_underflow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
    $finish;
  end

endmodule
